// File: rtl/dcpu_prog_loader_if.sv
// dcpu_prog_loader_if -- byte-stream load channel into the DCPU program loader.
//
// Signals:
//   LdValid  source -> loader  byte on LdByte is valid
//   LdByte   source -> loader  load byte; each 16-bit word is sent high byte first
//   LdLast   source -> loader  marks the final word (only looked at with a low byte)
//   LdReady  loader -> source  loader can accept a byte this cycle
//
// Modports: master = byte source, slave = loader.
interface dcpu_prog_loader_if;
    logic       LdValid;
    logic [7:0] LdByte;
    logic       LdLast;
    logic       LdReady;

    modport master (output LdValid, output LdByte, output LdLast, input LdReady);
    modport slave  (input LdValid, input LdByte, input LdLast, output LdReady);
endinterface

// File: rtl/dcpu_prog_loader.sv
// dcpu_prog_loader -- program loader and instruction store for the DCPU core.
//
// Packs an incoming byte stream (high byte first) into 16-bit words, writes
// them to a 2^ADDR_W x 16 instruction RAM, then raises Start and serves Inst
// combinationally from InstMemAddr. Outside RUN, Inst reads as NOP (0).
//
// Ports:
//   CLK, RST     clock; asynchronous active-high reset
//   ld           load byte channel (slave side of dcpu_prog_loader_if)
//   Reload       one-cycle pulse; in RUN/ERR restarts loading at address 0
//   InstMemAddr  fetch address from DCPU
//   Inst         instruction word to DCPU (0 unless in RUN)
//   Start        run enable, high only in RUN
//   Err          checksum failure, high only in ERR
//   WordCount    words written in the current load
//
// Build option: define DCPU_LOADER_CHECKSUM_EN to expect a modulo-256 sum
// byte after the last word; a mismatch parks the loader in ERR.
module dcpu_prog_loader #(
    parameter int ADDR_W = 8
) (
    input  logic                CLK,
    input  logic                RST,
    dcpu_prog_loader_if.slave   ld,
    input  logic                Reload,
    input  logic [ADDR_W-1:0]   InstMemAddr,
    output logic [15:0]         Inst,
    output logic                Start,
    output logic                Err,
    output logic [ADDR_W:0]     WordCount
);

`ifdef DCPU_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {LOAD_HI, LOAD_LO, CKSUM, RUN, ERR} state_t;
`else
    typedef enum logic [2:0] {LOAD_HI, LOAD_LO, RUN} state_t;
`endif

    state_t              state, stateNext;
    logic [ADDR_W-1:0]   wptr;
    logic [7:0]          hiByte;
    logic                wrEn;      // low byte accepted: write word this edge
    logic                clrLoad;   // Reload honoured: restart pointers
    logic [15:0]         mem [2**ADDR_W];
`ifdef DCPU_LOADER_CHECKSUM_EN
    logic [7:0]          sum;
    logic                dataAcc;   // data byte (hi or lo) accepted
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= LOAD_HI;
        else     state <= stateNext;
    end

    // LdReady is a pure state decode, so inside the load states a valid
    // byte is always an accepted byte.
    always_comb begin
        stateNext  = state;
        ld.LdReady = 1'b0;
        wrEn       = 1'b0;
        clrLoad    = 1'b0;
        Start      = 1'b0;
        Err        = 1'b0;
`ifdef DCPU_LOADER_CHECKSUM_EN
        dataAcc    = 1'b0;
`endif
        case (state)
            LOAD_HI: begin
                ld.LdReady = 1'b1;
`ifdef DCPU_LOADER_CHECKSUM_EN
                dataAcc    = ld.LdValid;
`endif
                if (ld.LdValid) stateNext = LOAD_LO;
            end
            LOAD_LO: begin
                ld.LdReady = 1'b1;
`ifdef DCPU_LOADER_CHECKSUM_EN
                dataAcc    = ld.LdValid;
`endif
                if (ld.LdValid) begin
                    wrEn = 1'b1;
                    // Last slot written ends the load even without LdLast.
                    if (ld.LdLast || wptr == '1)
`ifdef DCPU_LOADER_CHECKSUM_EN
                        stateNext = CKSUM;
`else
                        stateNext = RUN;
`endif
                    else
                        stateNext = LOAD_HI;
                end
            end
`ifdef DCPU_LOADER_CHECKSUM_EN
            CKSUM: begin
                ld.LdReady = 1'b1;
                if (ld.LdValid) stateNext = (ld.LdByte == sum) ? RUN : ERR;
            end
            ERR: begin
                Err = 1'b1;
                if (Reload) begin
                    stateNext = LOAD_HI;
                    clrLoad   = 1'b1;
                end
            end
`endif
            RUN: begin
                Start = 1'b1;
                if (Reload) begin
                    stateNext = LOAD_HI;
                    clrLoad   = 1'b1;
                end
            end
            default: stateNext = LOAD_HI;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr      <= '0;
            WordCount <= '0;
            hiByte    <= '0;
`ifdef DCPU_LOADER_CHECKSUM_EN
            sum       <= '0;
`endif
        end else if (clrLoad) begin
            wptr      <= '0;
            WordCount <= '0;
`ifdef DCPU_LOADER_CHECKSUM_EN
            sum       <= '0;
`endif
        end else begin
            if (state == LOAD_HI && ld.LdValid) hiByte <= ld.LdByte;
            if (wrEn) begin
                // Saturate at the top slot: a full load never wraps onto word 0.
                if (wptr != '1) wptr <= wptr + 1'b1;
                WordCount <= WordCount + 1'b1;
            end
`ifdef DCPU_LOADER_CHECKSUM_EN
            if (dataAcc) sum <= sum + ld.LdByte;
`endif
        end
    end

    // RAM is not reset; stale contents are hidden by the NOP mux below.
    always_ff @(posedge CLK) begin
        if (wrEn) mem[wptr] <= {hiByte, ld.LdByte};
    end

    assign Inst = (state == RUN) ? mem[InstMemAddr] : 16'h0000;

endmodule

// File: doc/dcpu_prog_loader.md
# dcpu_prog_loader

Program loader and instruction store for the DCPU core. It accepts a byte stream over a valid/ready handshake, packs byte pairs into 16-bit instruction words, and writes them into a 2^ADDR_W-entry instruction RAM. When the load completes it asserts `Start` and serves `Inst` combinationally from `InstMemAddr`. It sits directly upstream of DCPU and drives the core's `Inst` and `Start` inputs.

## Interface
- `ADDR_W`, default 8: instruction address width; RAM depth is 2^ADDR_W words of 16 bits.
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `LdValid`  in  1  load byte valid.
- `LdByte`  in  8  load byte; each word is sent high byte first.
- `LdLast`  in  1  marks the final word; sampled only with a low byte.
- `LdReady`  out  1  loader can accept a byte.
- `Reload`  in  1  single-cycle pulse; restarts loading from address 0.
- `InstMemAddr`  in  ADDR_W  instruction fetch address from DCPU.
- `Inst`  out  16  instruction word to DCPU.
- `Start`  out  1  run enable to DCPU; high only in RUN.
- `Err`  out  1  checksum failure; high only in ERR.
- `WordCount`  out  ADDR_W+1  number of words written in the current load.

## Operation
- States: LOAD_HI, LOAD_LO, CKSUM, RUN, ERR. Reset state is LOAD_HI.
- A byte is accepted on a rising edge where `LdValid && LdReady`.
- `LdReady` is 1 in LOAD_HI, LOAD_LO and CKSUM, and 0 in RUN and ERR. It is decoded from state.
- LOAD_HI: accepting a byte latches it as the high byte and moves to LOAD_LO. `LdLast` is ignored in this state.
- LOAD_LO: accepting a byte writes `mem[wptr] <= {hi, LdByte}`, increments `wptr` and increments `WordCount`.
  - The load ends if `LdLast` = 1, or if `wptr` = 2^ADDR_W-1 (forced end on full; no wrap, no overwrite).
  - On end, go to CKSUM if the macro is defined, otherwise RUN. If the load does not end, go to LOAD_HI.
- Running sum: an 8-bit modulo-256 sum of every accepted data byte (high and low).
- CKSUM: accepting a byte compares it with the running sum. Equal goes to RUN; unequal goes to ERR.
- RUN: `Inst = mem[InstMemAddr]`, combinational read.
- In every state other than RUN, `Inst` = 16'h0000 (NOP), so a stray fetch never sees stale code.
- `Reload` in RUN or ERR: go to LOAD_HI and clear `wptr`, `WordCount` and the sum. `Reload` in the load states is ignored.
- `Reload` coinciding with byte acceptance is ignored.
- Reset values: `LdReady`=1, `Start`=0, `Err`=0, `Inst`=0, `WordCount`=0, `wptr`=0, sum=0. RAM contents are not cleared.
- Reset mid-load abandons the load. Any words already written remain in RAM but are unreachable until the next completed load.

## Timing
- Write latency: the word is in RAM on the edge that accepts its low byte. It is readable in RUN the same cycle RUN is entered.
- `Start` rises the cycle after the edge that accepts the final low byte, or the checksum byte when the macro is defined.
- `Start` falls the cycle after a `Reload` edge.
- Minimum load time is 2N cycles for N words, plus 1 cycle with the checksum.
- Back-to-back bytes are accepted every cycle; there are no bubbles.
- `Inst` has a zero-cycle path from `InstMemAddr` and from state. No registered output stage.

## Configuration
- `DCPU_LOADER_CHECKSUM_EN` defined: CKSUM state exists, a checksum byte follows the last word, and a mismatch goes to ERR with `Err`=1 and `Start`=0.
- Not defined: CKSUM and ERR are unreachable and removed. The sum logic is removed, `Err` is tied to 0, and the end of a load goes directly to RUN.

## Test plan
- Load 3 words 0x1000, 0xB802, 0x3020 (bytes 10 00 B8 02 30 20, `LdLast` on the last byte) -> `Start`=1 one cycle later, `WordCount`=3, `InstMemAddr`=1 gives `Inst`=0xB802.
- Same load with `LdValid` toggling 1/0 each cycle -> identical RAM contents; `LdReady` stays 1 until the end.
- With the checksum macro, the 6 bytes above followed by 0x1A (sum 0x1A) -> RUN. The same bytes followed by 0x1B -> `Err`=1, `Start`=0, `Inst`=0; then a `Reload` pulse -> `Err`=0, `LdReady`=1.
- Load 2^ADDR_W words with no `LdLast` -> forced end after word 255, `WordCount`=256, `mem[0]` not overwritten.
- Assert `RST` after 3 bytes -> next cycle `LdReady`=1, `Start`=0, `WordCount`=0. A fresh 1-word load then reads back at address 0.
- In RUN, pulse `Reload` -> `Start`=0 the next cycle and `Inst`=0 for any `InstMemAddr`.
